// File: rtl/kamus_pkg.sv
// Shared types and op-decoding helpers for the kamus load/store unit.
package kamus_pkg;

  // Encoding: op[1:0] is log2(access bytes), op[2] marks zero-extending loads, op[3] marks stores.
  typedef enum logic [3:0] {
    OpLb  = 4'h0,
    OpLh  = 4'h1,
    OpLw  = 4'h2,
    OpLd  = 4'h3,
    OpLbu = 4'h4,
    OpLhu = 4'h5,
    OpLwu = 4'h6,
    OpSb  = 4'h8,
    OpSh  = 4'h9,
    OpSw  = 4'hA,
    OpSd  = 4'hB
  } lsu_op_e;

  typedef logic [1:0] lsu_state_e;
  localparam lsu_state_e StIdle  = 2'd0;
  localparam lsu_state_e StReq   = 2'd1;
  localparam lsu_state_e StWaitR = 2'd2;

  function automatic logic [1:0] op_size(input logic [3:0] op);
    return op[1:0];
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic op_is_signed(input logic [3:0] op);
    return !op[3] && !op[2];
  endfunction

  // Unused encodings and 64-bit-only ops on a 32-bit datapath are rejected.
  function automatic logic op_legal(input logic [3:0] op, input int unsigned xlen);
    logic enc_ok;
    enc_ok = (op != 4'h7) && (op[3:2] != 2'b11);
    return enc_ok && !((xlen == 32) && ((op[1:0] == 2'b11) || (op == OpLwu)));
  endfunction

endpackage

// File: rtl/kamus_lsu_align.sv
// Combinational lane logic: byte enables, store-data shift, alignment fault, load extension.
module kamus_lsu_align
  import kamus_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]        op_i,
  input  logic [2:0]        addr_lo_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [XLEN/8-1:0] be_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              fault_o,
  output logic [XLEN-1:0]   ldata_o
);

  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned OFS_W  = $clog2(NBYTES);

  logic [1:0]       size;
  logic [OFS_W-1:0] ofs;
  logic [OFS_W+2:0] shamt;
  logic [15:0]      be_wide;
  logic [XLEN-1:0]  shifted;
  logic             misalign;
  logic             sign_bit;
  logic             ext_bit;
  int unsigned      nbits;

  assign size  = op_size(op_i);
  assign ofs   = addr_lo_i[OFS_W-1:0];
  assign shamt = {ofs, 3'b000};

  // Natural alignment per access size, plus illegal ops folded into one fault.
  always_comb begin
    misalign = 1'b0;
    case (size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = addr_lo_i[0];
      2'd2:    misalign = |addr_lo_i[1:0];
      default: misalign = |addr_lo_i;
    endcase
    fault_o = misalign || !op_legal(op_i, XLEN);
  end

  // Byte enables and lane-shifted store data.
  always_comb begin
    be_wide = ((16'd1 << (16'd1 << size)) - 16'd1) << ofs;
    be_o    = be_wide[NBYTES-1:0];
    wdata_o = wdata_i << shamt;
  end

  // Pull the addressed bytes down to bit 0 and fill the rest with sign or zero.
  always_comb begin
    shifted = rdata_i >> shamt;
    nbits   = 32'd8 << size;
    case (size)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[XLEN-1];
    endcase
    ext_bit = sign_bit && op_is_signed(op_i);
    ldata_o = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      ldata_o[i] = (i < nbits) ? shifted[i] : ext_bit;
    end
  end

endmodule

// File: rtl/kamus_lsu_ctrl.sv
// Load/store unit: EX handshake, L1D req/gnt/rvalid sequencing, WB result and fault pulses.
module kamus_lsu_ctrl
  import kamus_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned NBYTES = XLEN / 8,
  localparam int unsigned OFS_W  = $clog2(NBYTES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [3:0]        ex_op_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [XLEN-1:0]   ex_wdata_i,
  input  logic [4:0]        ex_rd_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [NBYTES-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] fault_addr_o,
  output logic              busy_o
);

  lsu_state_e        state_q, state_d;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [4:0]        rd_q;
  logic              squash_q;
  logic              wb_valid_q;
  logic [4:0]        wb_rd_q;
  logic [XLEN-1:0]   wb_data_q;
  logic              mis_q;
  logic [ADDR_W-1:0] fault_addr_q;

  logic              is_idle, in_req, accept;
  logic [3:0]        a_op;
  logic [ADDR_W-1:0] a_addr;
  logic [XLEN-1:0]   a_wdata;
  logic [NBYTES-1:0] a_be;
  logic [XLEN-1:0]   a_wdata_sh;
  logic [XLEN-1:0]   a_ldata;
  logic              a_fault;

  assign is_idle    = (state_q == StIdle);
  assign in_req     = (state_q == StReq);
  assign ex_ready_o = is_idle && !rst_i;
  assign accept     = ex_valid_i && ex_ready_o && !flush_i;

  // In IDLE the aligner checks the incoming op; afterwards it works on the latched op.
  assign a_op    = is_idle ? ex_op_i : op_q;
  assign a_addr  = is_idle ? ex_addr_i : addr_q;
  assign a_wdata = is_idle ? ex_wdata_i : wdata_q;

  kamus_lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .op_i     (a_op),
    .addr_lo_i(a_addr[2:0]),
    .wdata_i  (a_wdata),
    .rdata_i  (dmem_rdata_i),
    .be_o     (a_be),
    .wdata_o  (a_wdata_sh),
    .fault_o  (a_fault),
    .ldata_o  (a_ldata)
  );

  // Next-state: faults never leave IDLE; gnt beats a same-cycle flush.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && !a_fault) state_d = StReq;
      StReq: begin
        if (dmem_gnt_i)   state_d = op_is_store(op_q) ? StIdle : StWaitR;
        else if (flush_i) state_d = StIdle;
      end
      StWaitR: if (dmem_rvalid_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, operand latches and one-cycle result/fault pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      squash_q     <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      mis_q        <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      if (accept) begin
        op_q     <= ex_op_i;
        addr_q   <= ex_addr_i;
        wdata_q  <= ex_wdata_i;
        rd_q     <= ex_rd_i;
        squash_q <= 1'b0;
        if (a_fault) begin
          mis_q        <= 1'b1;
          fault_addr_q <= ex_addr_i;
        end
      end
      if (in_req && dmem_gnt_i && flush_i) squash_q <= 1'b1;
      if (state_q == StWaitR) begin
        if (flush_i) squash_q <= 1'b1;
        if (dmem_rvalid_i && !squash_q && !flush_i) begin
          wb_valid_q <= 1'b1;
          wb_data_q  <= a_ldata;
          wb_rd_q    <= rd_q;
        end
      end
    end
  end

  assign dmem_req_o   = in_req;
  assign dmem_we_o    = in_req && op_is_store(op_q);
  assign dmem_addr_o  = in_req ? {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}} : '0;
  assign dmem_be_o    = in_req ? a_be : '0;
  assign dmem_wdata_o = in_req ? a_wdata_sh : '0;
  assign wb_valid_o   = wb_valid_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_data_o    = wb_data_q;
  assign misalign_o   = mis_q;
  assign fault_addr_o = fault_addr_q;
  assign busy_o       = !is_idle;

endmodule

// File: tb/tb_kamus_lsu_ctrl.sv
// Bench for kamus_lsu_ctrl: 32- and 64-bit instances share stimulus; one is observed at a time.
module tb_kamus_lsu_ctrl;
  import kamus_pkg::*;

  logic        clk, rst, flush, ex_valid, gnt, rvalid;
  logic [3:0]  ex_op;
  logic [31:0] ex_addr;
  logic [63:0] ex_wdata, rdata;
  logic [4:0]  ex_rd;

  logic        r32_ready, r32_req, r32_we, r32_wbv, r32_mis, r32_busy;
  logic [31:0] r32_addr, r32_wdata, r32_wbd, r32_fault;
  logic [3:0]  r32_be;
  logic [4:0]  r32_rd;
  logic        r64_ready, r64_req, r64_we, r64_wbv, r64_mis, r64_busy;
  logic [31:0] r64_addr, r64_fault;
  logic [63:0] r64_wdata, r64_wbd;
  logic [7:0]  r64_be;
  logic [4:0]  r64_rd;

  kamus_lsu_ctrl #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .ex_valid_i(ex_valid), .ex_ready_o(r32_ready),
    .ex_op_i(ex_op), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata[31:0]), .ex_rd_i(ex_rd),
    .dmem_req_o(r32_req), .dmem_we_o(r32_we), .dmem_addr_o(r32_addr), .dmem_be_o(r32_be),
    .dmem_wdata_o(r32_wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
    .dmem_rdata_i(rdata[31:0]), .wb_valid_o(r32_wbv), .wb_rd_o(r32_rd), .wb_data_o(r32_wbd),
    .misalign_o(r32_mis), .fault_addr_o(r32_fault), .busy_o(r32_busy)
  );

  kamus_lsu_ctrl #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .ex_valid_i(ex_valid), .ex_ready_o(r64_ready),
    .ex_op_i(ex_op), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata), .ex_rd_i(ex_rd),
    .dmem_req_o(r64_req), .dmem_we_o(r64_we), .dmem_addr_o(r64_addr), .dmem_be_o(r64_be),
    .dmem_wdata_o(r64_wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
    .dmem_rdata_i(rdata), .wb_valid_o(r64_wbv), .wb_rd_o(r64_rd), .wb_data_o(r64_wbd),
    .misalign_o(r64_mis), .fault_addr_o(r64_fault), .busy_o(r64_busy)
  );

  bit          sel64;
  logic        s_ready, s_req, s_we, s_wbv, s_mis, s_busy;
  logic [31:0] s_addr, s_fault;
  logic [7:0]  s_be;
  logic [63:0] s_wdata, s_wbd;
  logic [4:0]  s_rd;
  assign s_ready = sel64 ? r64_ready : r32_ready;
  assign s_req   = sel64 ? r64_req : r32_req;
  assign s_we    = sel64 ? r64_we : r32_we;
  assign s_wbv   = sel64 ? r64_wbv : r32_wbv;
  assign s_mis   = sel64 ? r64_mis : r32_mis;
  assign s_busy  = sel64 ? r64_busy : r32_busy;
  assign s_addr  = sel64 ? r64_addr : r32_addr;
  assign s_fault = sel64 ? r64_fault : r32_fault;
  assign s_be    = sel64 ? r64_be : {4'b0, r32_be};
  assign s_wdata = sel64 ? r64_wdata : {32'b0, r32_wdata};
  assign s_wbd   = sel64 ? r64_wbd : {32'b0, r32_wbd};
  assign s_rd    = sel64 ? r64_rd : r32_rd;

  int errors = 0;
  int checks = 0;

  // Observations of the last run_op, indexed by cycle relative to the accept cycle (0).
  int          o_req_n, o_first_req, o_wb_n, o_wb_cycle, o_mis_n, o_ready_cycle;
  bit          o_stable;
  logic        o_we, o_busy_end;
  logic [7:0]  o_be;
  logic [31:0] o_addr, o_fault;
  logic [63:0] o_wdata, o_wb_data;
  logic [4:0]  o_wb_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [3:0] op);
    case (op)
      OpLb, OpLbu, OpSb: return 0;
      OpLh, OpLhu, OpSh: return 1;
      OpLw, OpLwu, OpSw: return 2;
      default:           return 3;
    endcase
  endfunction

  function automatic bit m_load(input logic [3:0] op);
    return op inside {OpLb, OpLh, OpLw, OpLd, OpLbu, OpLhu, OpLwu};
  endfunction

  function automatic bit m_illegal(input logic [3:0] op, input logic [31:0] a, input int xl);
    if (xl == 32 && (op inside {OpLd, OpLwu, OpSd})) return 1'b1;
    return (a % (32'd1 << m_size(op))) != 0;
  endfunction

  function automatic logic [7:0] m_be(input logic [3:0] op, input logic [31:0] a, input int xl);
    int nb = 1 << m_size(op);
    int o = int'(a % (xl / 8));
    logic [15:0] m;
    m = ((16'd1 << nb) - 16'd1) << o;
    return m[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] w, input logic [31:0] a, input int xl);
    logic [63:0] v;
    v = w << (8 * (a % (xl / 8)));
    if (xl == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic logic [63:0] m_load_val(input logic [3:0] op, input logic [31:0] a,
                                             input logic [63:0] r, input int xl);
    logic [63:0] v, mask;
    int nbits = 8 << m_size(op);
    v = (xl == 32) ? (r & 64'hFFFF_FFFF) : r;
    v = v >> (8 * (a % (xl / 8)));
    mask = (nbits == 64) ? '1 : ((64'd1 << nbits) - 64'd1);
    v = v & mask;
    if ((op inside {OpLb, OpLh, OpLw}) && v[nbits-1]) v = v | ~mask;
    if (xl == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b1; flush = 0; ex_valid = 0; gnt = 0; rvalid = 0;
    ex_op = '0; ex_addr = '0; ex_wdata = '0; ex_rd = '0; rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // mode: 0 none, 1 flush in first WAIT_R cycle, 2 flush with gnt, 3 flush in REQ (no gnt),
  // 4 flush on the accept cycle. gnt expected g cycles after req rises, rvalid rv after that.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [63:0] w,
                        input logic [63:0] rd_data, input logic [4:0] rd, input int g,
                        input int rv, input int mode);
    int ncyc = g + rv + 8;
    int gnt_c = 1 + g;
    int rv_c = 2 + g + rv;
    o_req_n = 0; o_first_req = -1; o_stable = 1'b1; o_wb_n = 0; o_wb_cycle = -1;
    o_mis_n = 0; o_ready_cycle = -1;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = op; ex_addr = a; ex_wdata = w; ex_rd = rd; flush = (mode == 4);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      ex_valid = 1'b0;
      gnt    = (mode != 3) && (c == gnt_c);
      rvalid = (mode != 3) && (c == rv_c);
      rdata  = rd_data;
      flush  = (mode == 1 && c == gnt_c + 1) || (mode == 2 && c == gnt_c) ||
               (mode == 3 && c == 1);
      @(negedge clk);
      if (s_req) begin
        o_req_n++;
        if (o_first_req < 0) begin
          o_first_req = c; o_be = s_be; o_addr = s_addr; o_wdata = s_wdata; o_we = s_we;
        end else if (s_be !== o_be || s_addr !== o_addr || s_wdata !== o_wdata || s_we !== o_we)
          o_stable = 1'b0;
      end
      if (s_wbv) begin
        o_wb_n++; o_wb_cycle = c; o_wb_data = s_wbd; o_wb_rd = s_rd;
      end
      if (s_mis) begin
        o_mis_n++; o_fault = s_fault;
      end
      if (s_ready && o_ready_cycle < 0) o_ready_cycle = c;
      o_busy_end = s_busy;
    end
    gnt = 0; rvalid = 0; flush = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel64 = 1'b0;
    rst = 1'b1; flush = 0; ex_valid = 0; gnt = 0; rvalid = 0;
    ex_op = '0; ex_addr = '0; ex_wdata = '0; ex_rd = '0; rdata = '0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b expected 0", s_ready);
    end
    checks++;
    if ({s_req, s_we, s_wbv, s_mis, s_busy, s_addr, s_be, s_wdata, s_wbd, s_fault} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b wbv=%b mis=%b busy=%b addr=%h be=%h expected all 0",
               s_req, s_we, s_wbv, s_mis, s_busy, s_addr, s_be);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", s_ready);
    end
  endtask

  task automatic test_store_word();
    sel64 = 1'b0; do_reset();
    run_op(OpSw, 32'h100, 64'hDEAD_BEEF, 64'h0, 5'd1, 0, 0, 0);
    checks++;
    if (o_first_req !== 1 || o_req_n !== 1) begin
      errors++; $display("FAIL sw_req: first=%0d n=%0d expected 1/1", o_first_req, o_req_n);
    end
    checks++;
    if (o_be !== 8'h0F || o_addr !== 32'h100 || o_we !== 1'b1) begin
      errors++; $display("FAIL sw_be_addr: be=%h addr=%h we=%b expected 0f/100/1", o_be, o_addr, o_we);
    end
    checks++;
    if (o_wdata !== 64'hDEAD_BEEF) begin
      errors++; $display("FAIL sw_wdata: got %h expected deadbeef", o_wdata);
    end
    checks++;
    if (o_ready_cycle !== 2) begin
      errors++; $display("FAIL sw_ready_cycle: got %0d expected 2", o_ready_cycle);
    end
  endtask

  task automatic test_store_byte();
    sel64 = 1'b0; do_reset();
    run_op(OpSb, 32'h103, 64'h1234_56A5, 64'h0, 5'd1, 0, 0, 0);
    checks++;
    if (o_be !== 8'h08 || o_wdata !== 64'hA500_0000 || o_addr !== 32'h100) begin
      errors++;
      $display("FAIL sb_lane: be=%h wdata=%h addr=%h expected 08/a5000000/100", o_be, o_wdata, o_addr);
    end
  endtask

  task automatic test_load_sign();
    sel64 = 1'b0; do_reset();
    run_op(OpLb, 32'h102, 64'h0080_0000, 64'h0080_0000, 5'd7, 0, 0, 0);
    checks++;
    if (o_wb_n !== 1 || o_wb_cycle !== 3) begin
      errors++; $display("FAIL lb_wb_timing: n=%0d cycle=%0d expected 1/3", o_wb_n, o_wb_cycle);
    end
    checks++;
    if (o_wb_data !== 64'hFFFF_FF80 || o_wb_rd !== 5'd7) begin
      errors++; $display("FAIL lb_data: got %h rd=%0d expected ffffff80 rd=7", o_wb_data, o_wb_rd);
    end
    run_op(OpLbu, 32'h102, 64'h0, 64'h0080_0000, 5'd9, 0, 0, 0);
    checks++;
    if (o_wb_data !== 64'h0000_0080 || o_wb_cycle !== 3) begin
      errors++; $display("FAIL lbu_data: got %h cycle=%0d expected 80/3", o_wb_data, o_wb_cycle);
    end
  endtask

  task automatic test_misalign();
    sel64 = 1'b0; do_reset();
    run_op(OpLw, 32'h102, 64'h0, 64'h1234_5678, 5'd3, 0, 0, 0);
    checks++;
    if (o_req_n !== 0 || o_wb_n !== 0) begin
      errors++; $display("FAIL lw_mis_noreq: req=%0d wb=%0d expected 0/0", o_req_n, o_wb_n);
    end
    checks++;
    if (o_mis_n !== 1 || o_fault !== 32'h102) begin
      errors++; $display("FAIL lw_mis_pulse: n=%0d fault=%h expected 1/102", o_mis_n, o_fault);
    end
  endtask

  task automatic test_flush_wait();
    sel64 = 1'b0; do_reset();
    run_op(OpLw, 32'h104, 64'h0, 64'hCAFE_F00D, 5'd4, 3, 1, 1);
    checks++;
    if (o_req_n !== 4 || o_stable !== 1'b1 || o_addr !== 32'h104 || o_be !== 8'h0F) begin
      errors++;
      $display("FAIL flush_wait_req: n=%0d stable=%b addr=%h be=%h expected 4/1/104/0f",
               o_req_n, o_stable, o_addr, o_be);
    end
    checks++;
    if (o_wb_n !== 0 || o_busy_end !== 1'b0) begin
      errors++; $display("FAIL flush_wait_wb: wb=%0d busy=%b expected 0/0", o_wb_n, o_busy_end);
    end
  endtask

  task automatic test_flush_req();
    sel64 = 1'b0; do_reset();
    run_op(OpLw, 32'h100, 64'h0, 64'h0, 5'd2, 2, 0, 3);
    checks++;
    if (o_req_n !== 1 || o_ready_cycle !== 2 || o_wb_n !== 0) begin
      errors++; $display("FAIL flush_req: req=%0d ready=%0d wb=%0d expected 1/2/0",
                         o_req_n, o_ready_cycle, o_wb_n);
    end
  endtask

  task automatic test_flush_gnt();
    sel64 = 1'b0; do_reset();
    run_op(OpSw, 32'h108, 64'h55, 64'h0, 5'd2, 1, 0, 2);
    checks++;
    if (o_req_n !== 2 || o_ready_cycle !== 3) begin
      errors++; $display("FAIL flush_gnt_store: req=%0d ready=%0d expected 2/3", o_req_n, o_ready_cycle);
    end
    run_op(OpLw, 32'h108, 64'h0, 64'h1111_2222, 5'd2, 1, 0, 2);
    checks++;
    if (o_wb_n !== 0 || o_ready_cycle !== 4) begin
      errors++; $display("FAIL flush_gnt_load: wb=%0d ready=%0d expected 0/4", o_wb_n, o_ready_cycle);
    end
  endtask

  task automatic test_flush_idle();
    sel64 = 1'b0; do_reset();
    run_op(OpLw, 32'h100, 64'h0, 64'h0, 5'd2, 0, 0, 4);
    checks++;
    if (o_req_n !== 0 || o_wb_n !== 0 || o_ready_cycle !== 1) begin
      errors++; $display("FAIL flush_idle_accept: req=%0d wb=%0d ready=%0d expected 0/0/1",
                         o_req_n, o_wb_n, o_ready_cycle);
    end
    run_op(OpLw, 32'h102, 64'h0, 64'h0, 5'd2, 0, 0, 4);
    checks++;
    if (o_mis_n !== 0) begin
      errors++; $display("FAIL flush_idle_mis: pulses=%0d expected 0", o_mis_n);
    end
  endtask

  task automatic test_rvalid_idle();
    int seen = 0;
    sel64 = 1'b0; do_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1 rvalid = 1'b1; rdata = 64'h1234;
      @(negedge clk);
      if (s_wbv || s_busy) seen++;
    end
    rvalid = 1'b0;
    @(negedge clk);
    if (s_wbv) seen++;
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rvalid_idle: got %0d wb/busy cycles expected 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    sel64 = 1'b0; do_reset();
    @(posedge clk); #1 ex_valid = 1'b1; ex_op = OpLw; ex_addr = 32'h100; ex_rd = 5'd6;
    @(posedge clk); #1 ex_valid = 1'b0; gnt = 1'b1;
    @(posedge clk); #1 gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (s_busy !== 1'b0 || s_req !== 1'b0) begin
      errors++; $display("FAIL reset_mid_state: busy=%b req=%b expected 0/0", s_busy, s_req);
    end
    @(posedge clk); #1 rst = 1'b0; rvalid = 1'b1; rdata = 64'hABCD;
    @(posedge clk); #1 rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (s_wbv) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_rvalid: wb=%0d ready=%b expected 0/1", seen, s_ready);
    end
  endtask

  task automatic test_xlen64();
    sel64 = 1'b1; do_reset();
    run_op(OpLd, 32'h8, 64'h0, 64'h8000_0000_0000_0001, 5'd10, 0, 0, 0);
    checks++;
    if (o_wb_n !== 1 || o_wb_data !== 64'h8000_0000_0000_0001 || o_be !== 8'hFF) begin
      errors++; $display("FAIL ld64: n=%0d data=%h be=%h expected 1/8000000000000001/ff",
                         o_wb_n, o_wb_data, o_be);
    end
    run_op(OpLh, 32'h6, 64'h0, 64'h8001_0000_0000_0000, 5'd11, 0, 0, 0);
    checks++;
    if (o_wb_data !== 64'hFFFF_FFFF_FFFF_8001 || o_be !== 8'hC0) begin
      errors++; $display("FAIL lh64: data=%h be=%h expected ffffffffffff8001/c0", o_wb_data, o_be);
    end
  endtask

  task automatic test_random(input bit s64, input int n);
    logic [3:0] ops [11];
    logic [3:0] op;
    logic [31:0] a;
    logic [63:0] w, r;
    logic [4:0] rd;
    int xl, g, rv, mode, sel, e_req, e_mis, e_wb, e_ready;
    bit ill, ld, live;
    ops = '{OpLb, OpLh, OpLw, OpLd, OpLbu, OpLhu, OpLwu, OpSb, OpSh, OpSw, OpSd};
    xl = s64 ? 64 : 32;
    sel64 = s64; do_reset();
    for (int k = 0; k < n; k++) begin
      op = ops[$urandom_range(0, 10)];
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~32'h7;
      w = {$urandom, $urandom}; r = {$urandom, $urandom};
      rd = 5'($urandom_range(0, 31));
      g = $urandom_range(0, 3); rv = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      mode = (sel <= 5) ? 0 : sel - 5;
      ill = m_illegal(op, a, xl); ld = m_load(op); live = !ill && mode != 4;
      e_req = !live ? 0 : (mode == 3) ? 1 : g + 1;
      e_mis = (ill && mode != 4) ? 1 : 0;
      e_wb = (live && ld && mode == 0) ? 1 : 0;
      e_ready = !live ? 1 : (mode == 3) ? 2 : ld ? 3 + g + rv : 2 + g;
      run_op(op, a, w, r, rd, g, rv, mode);
      checks++;
      if (o_req_n !== e_req || o_mis_n !== e_mis || o_wb_n !== e_wb || o_ready_cycle !== e_ready) begin
        errors++;
        $display("FAIL rnd_flow x%0d op=%h a=%h m=%0d: req/mis/wb/ready=%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                 xl, op, a, mode, o_req_n, o_mis_n, o_wb_n, o_ready_cycle,
                 e_req, e_mis, e_wb, e_ready);
      end
      if (live) begin
        checks++;
        if (o_be !== m_be(op, a, xl) || o_addr !== (a & ~32'(xl / 8 - 1)) || o_we !== !ld ||
            o_stable !== 1'b1) begin
          errors++;
          $display("FAIL rnd_req x%0d op=%h a=%h: be=%h addr=%h we=%b stable=%b expected be=%h addr=%h we=%b",
                   xl, op, a, o_be, o_addr, o_we, o_stable, m_be(op, a, xl),
                   a & ~32'(xl / 8 - 1), !ld);
        end
        if (!ld) begin
          checks++;
          if (o_wdata !== m_wdata(w, a, xl)) begin
            errors++;
            $display("FAIL rnd_wdata x%0d op=%h a=%h: got %h expected %h", xl, op, a, o_wdata,
                     m_wdata(w, a, xl));
          end
        end
      end
      if (e_wb == 1) begin
        checks++;
        if (o_wb_data !== m_load_val(op, a, r, xl) || o_wb_rd !== rd) begin
          errors++;
          $display("FAIL rnd_load x%0d op=%h a=%h: data=%h rd=%0d expected %h rd=%0d", xl, op, a,
                   o_wb_data, o_wb_rd, m_load_val(op, a, r, xl), rd);
        end
      end
      if (e_mis == 1) begin
        checks++;
        if (o_fault !== a) begin
          errors++; $display("FAIL rnd_fault x%0d: got %h expected %h", xl, o_fault, a);
        end
      end
      checks++;
      if (o_busy_end !== 1'b0) begin
        errors++; $display("FAIL rnd_idle_end x%0d: busy=%b expected 0", xl, o_busy_end);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_sign();
    test_misalign();
    test_flush_wait();
    test_flush_req();
    test_flush_gnt();
    test_flush_idle();
    test_rvalid_idle();
    test_reset_mid();
    test_xlen64();
    test_random(1'b0, 60);
    test_random(1'b1, 60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kamus_lsu_ctrl.md
# kamus_lsu_ctrl

Parametrised load/store unit sitting between the EX stage and the L1 data-cache port. Accepts one memory op per handshake from EX (address = ALU result), generates byte-enables and lane-aligned store data, runs a req/gnt/rvalid transaction to L1D, and returns sign/zero-extended load data to WB with its destination register. Supports XLEN 32 or 64, detects misaligned accesses without touching memory, and supports pipeline flush.

## Interface
- XLEN, 32, data width; legal values 32 or 64
- ADDR_W, 32, byte-address width
- NBYTES, XLEN/8, derived; byte lanes per beat
- OFS_W, $clog2(NBYTES), derived; lane-offset bits

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- flush_i  in  1  abort current op (pipeline squash)
- ex_valid_i  in  1  EX presents an op
- ex_ready_o  out  1  LSU can accept (state IDLE and not rst_i)
- ex_op_i  in  4  lsu_op_e: LB,LH,LW,LD,LBU,LHU,LWU,SB,SH,SW,SD
- ex_addr_i  in  ADDR_W  byte address from ALU
- ex_wdata_i  in  XLEN  store data from regfile, LSB-justified
- ex_rd_i  in  5  load destination register
- dmem_req_o  out  1  L1D request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  ADDR_W  beat-aligned address (low OFS_W bits 0)
- dmem_be_o  out  NBYTES  byte enables
- dmem_wdata_o  out  XLEN  lane-shifted store data
- dmem_gnt_i  in  1  L1D accepts request
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  XLEN  load beat
- wb_valid_o  out  1  one-cycle load-result pulse
- wb_rd_o  out  5  destination register
- wb_data_o  out  XLEN  extended load data
- misalign_o  out  1  one-cycle fault pulse
- fault_addr_o  out  ADDR_W  offending address
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, REQ, WAIT_R.
- IDLE: ex_ready_o=1. On ex_valid_i&&ex_ready_o: latch op/addr/wdata/rd. If access size misaligned (H: addr[0]; W: addr[1:0]; D: addr[2:0]) -> stay IDLE, pulse misalign_o next cycle with fault_addr_o=addr; no dmem request. Else -> REQ.
- LD/LWU/SD with XLEN=32: treated as illegal, reported via misalign_o (same timing).
- REQ: dmem_req_o=1; addr/we/be/wdata held stable until dmem_gnt_i. On gnt: store -> IDLE; load -> WAIT_R.
- WAIT_R: on dmem_rvalid_i -> extract lanes (rdata >> 8*ofs), sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU), register to wb_data_o, pulse wb_valid_o next cycle, -> IDLE.
- Byte enables: B = 1<<ofs; H = 2'b11<<ofs; W = 4'hF<<ofs; D = all ones. wdata = ex_wdata_i << 8*ofs.
- flush_i in REQ without gnt: drop request, -> IDLE. flush_i with gnt same cycle: gnt wins; store commits, load goes to WAIT_R with result marked squashed. flush_i in WAIT_R: stay until rvalid, then -> IDLE with no wb_valid_o. flush_i in IDLE overrides a same-cycle accept (op discarded) and suppresses a pending misalign_o pulse.
- rvalid_i outside WAIT_R ignored.

## Timing
- Reset: state IDLE; dmem_req_o, dmem_we_o, wb_valid_o, misalign_o, busy_o = 0; all data/address/be outputs = 0; ex_ready_o = 0 while rst_i high, 1 after.
- Reset mid-transaction: immediate return to IDLE; outstanding rvalid after reset ignored.
- Store, zero-wait gnt: accept cycle 0, req cycle 1, next accept cycle 2.
- Load, zero-wait gnt, rvalid one cycle after gnt: accept 0, req 1, rvalid 2, wb_valid_o 3.
- One outstanding op max; rvalid never same cycle as gnt.

## Structure
- kamus_pkg: lsu_op_e (4-bit enum), lsu_state_e, op-to-size/signed helper functions.
- Sub-module kamus_lsu_align: combinational be/wdata generation, misalignment check, load extraction/extension; instanced once.

## Test plan
- SW 0xDEADBEEF to 0x100, gnt immediate -> cycle 1 req, be=4'hF, addr=0x100, wdata=0xDEADBEEF; ready cycle 2.
- SB 0x..A5 to 0x103 -> be=4'b1000, wdata=0xA5000000.
- LB from 0x102, rdata=0x00800000 -> wb_data_o=0xFFFFFF80; LBU same -> 0x00000080; wb_valid_o cycle 3.
- LW from 0x102 -> no dmem_req_o, misalign_o pulse, fault_addr_o=0x102.
- Load with gnt delayed 3 cycles, flush_i in WAIT_R -> addr/be stable during wait, no wb_valid_o after rvalid.
- XLEN=64: LD 0x8, rdata=0x8000_0000_0000_0001 -> wb_data_o identical; LH 0x6 rdata=0x8001_0000_0000_0000 -> 0xFFFF_FFFF_FFFF_8001.
